// File: rtl/lcm_pkg.sv
// Shared types and constants for the sequential LCM/GCD unit.
package lcm_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [2:0] {
    StIdle,
    StGcd,
    StDiv,
    StMul,
    StDone
  } lcm_state_t;

endpackage

// File: rtl/lcm_seq_if.sv
// Start/done request bus of the LCM unit: operands in, results and status out.
interface lcm_seq_if import lcm_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   gcd;
  logic [2*WIDTH-1:0] lcm;

  modport master (
    output start, a, b,
    input  busy, done, gcd, lcm
  );

  modport slave (
    input  start, a, b,
    output busy, done, gcd, lcm
  );

endinterface

// File: rtl/lcm_div_restoring.sv
// WIDTH-step restoring divider, MSB first. The load cycle already performs the
// first step, so valid rises after WIDTH-1 further edges and the quotient is
// complete in the cycle valid is high. The remainder is kept internal only.
module lcm_div_restoring import lcm_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             valid,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] rem_in, quo_in, dsr_in, rem_next, quo_next;
  logic [WIDTH:0]   trial;
  logic             qbit;

  // One restoring step on either the freshly loaded operands or the running state.
  always_comb begin
    rem_in   = load ? '0       : rem_q;
    quo_in   = load ? dividend : quo_q;
    dsr_in   = load ? divisor  : dsr_q;
    trial    = {rem_in, quo_in[WIDTH-1]};
    qbit     = (trial >= {1'b0, dsr_in});
    rem_next = WIDTH'(qbit ? trial - {1'b0, dsr_in} : trial);
    quo_next = {quo_in[WIDTH-2:0], qbit};

    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load) begin
      rem_d   = rem_next;
      quo_d   = quo_next;
      dsr_d   = divisor;
      cnt_d   = CntW'(WIDTH - 1);
      valid_d = (WIDTH == 1);
    end else if (cnt_q != '0) begin
      rem_d   = rem_next;
      quo_d   = quo_next;
      cnt_d   = cnt_q - CntW'(1);
      valid_d = (cnt_q == CntW'(1));
    end
  end

  // Divider state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid    = valid_q;
  assign quotient = quo_q;

endmodule

// File: rtl/lcm_seq.sv
// Sequential LCM: subtractive GCD, restoring a/g, then shift-add (a/g)*b.
// Results are registered only on DONE entry and hold until the next one.
module lcm_seq import lcm_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic     clk,
  input logic     rst_n,
  lcm_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  lcm_state_t         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d, g_q, g_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   gcd_q, gcd_d;
  logic [2*WIDTH-1:0] lcm_q, lcm_d;

  logic               div_load;
  logic               div_valid;
  logic [WIDTH-1:0]   div_quo;

  lcm_div_restoring #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .dividend (a_q),
    .divisor  (x_q),
    .valid    (div_valid),
    .quotient (div_quo)
  );

  // Next-state and datapath: GCD loop, divider hand-off, MSB-first multiplier.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    g_d      = g_q;
    mq_d     = mq_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    gcd_d    = gcd_q;
    lcm_d    = lcm_q;
    div_load = 1'b0;
    acc_step = {acc_q[2*WIDTH-2:0], 1'b0} + (mq_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : '0);

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d = bus.a;
          b_d = bus.b;
          if (bus.a == '0 || bus.b == '0) begin
            gcd_d   = bus.a | bus.b;
            lcm_d   = '0;
            state_d = StDone;
          end else begin
            x_d     = bus.a;
            y_d     = bus.b;
            state_d = StGcd;
          end
        end
      end
      StGcd: begin
        if (x_q == y_q) begin
          g_d      = x_q;
          div_load = 1'b1;
          state_d  = StDiv;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      StDiv: begin
        if (div_valid) begin
          mq_d    = div_quo;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        acc_d = acc_step;
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          gcd_d   = g_q;
          lcm_d   = acc_step;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      g_q     <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      gcd_q   <= '0;
      lcm_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      g_q     <= g_d;
      mq_q    <= mq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gcd_q   <= gcd_d;
      lcm_q   <= lcm_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.gcd  = gcd_q;
  assign bus.lcm  = lcm_q;

endmodule

// File: tb/tb_lcm_seq.sv
// Self-checking bench for lcm_seq: directed table, held-start, mid-run reset,
// exhaustive WIDTH=4 sweep against a reference gcd/lcm/latency model.
module tb_lcm_seq;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0]   g;
    logic [2*W-1:0] l;
    int             lat;
  } exp_t;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   g;
    logic [2*W-1:0] l;
    int             lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lcm_seq_if #(.WIDTH(W)) bus ();

  lcm_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [W-1:0]   last_g = '0;
  logic [2*W-1:0] last_l = '0;
  logic [W-1:0]   cur_a, cur_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s a=%0d b=%0d: got %0d expected %0d", name, cur_a, cur_b, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] x, y;
    logic [2*W-1:0] q8, b8;
    int s;
    if (a == 0 || b == 0) begin
      e.g = a | b;
      e.l = '0;
      e.lat = 1;
    end else begin
      x = a;
      y = b;
      s = 0;
      while (x != y) begin
        if (x > y) x = x - y;
        else y = y - x;
        s++;
      end
      e.g = x;
      q8 = {{W{1'b0}}, a / x};
      b8 = {{W{1'b0}}, b};
      e.l = q8 * b8;
      e.lat = s + 2 * W + 2;
    end
    return e;
  endfunction

  // Issue one request from an IDLE cycle and score it when done appears.
  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    exp_t got;
    int n;
    bit seen, busy_ok, held;
    @(negedge clk);
    cur_a = a;
    cur_b = b;
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    sb.push_back(e);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    n = 0;
    seen = 0;
    busy_ok = 1;
    held = 1;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
      bus.a = ~a;
      bus.b = ~b;
      if (bus.busy !== 1'b1) busy_ok = 0;
      if (bus.done === 1'b1) seen = 1;
      else if (bus.gcd !== last_g || bus.lcm !== last_l) held = 0;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      got = sb.pop_front();
      chk("gcd", bus.gcd, got.g);
      chk("lcm", bus.lcm, got.l);
      chk("latency", n, got.lat);
      chk("busy_during", busy_ok, 1);
      chk("hold_during", held, 1);
      last_g = got.g;
      last_l = got.l;
    end else begin
      void'(sb.pop_front());
    end
  endtask

  vec_t vecs[6];

  initial begin
    int n, dones, done_n;
    bit stray;
    exp_t e;

    vecs[0] = '{a: 4'd4,  b: 4'd6,  g: 4'd2,  l: 8'd12,  lat: 12};
    vecs[1] = '{a: 4'd15, b: 4'd14, g: 4'd1,  l: 8'd210, lat: 24};
    vecs[2] = '{a: 4'd15, b: 4'd15, g: 4'd15, l: 8'd15,  lat: 10};
    vecs[3] = '{a: 4'd0,  b: 4'd9,  g: 4'd9,  l: 8'd0,   lat: 1};
    vecs[4] = '{a: 4'd0,  b: 4'd0,  g: 4'd0,  l: 8'd0,   lat: 1};
    vecs[5] = '{a: 4'd12, b: 4'd8,  g: 4'd4,  l: 8'd24,  lat: 12};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    cur_a = '0;
    cur_b = '0;

    // Reset state.
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_gcd", bus.gcd, 0);
    chk("rst_lcm", bus.lcm, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table, issued back to back.
    for (int i = 0; i < 6; i++) begin
      e.g = vecs[i].g;
      e.l = vecs[i].l;
      e.lat = vecs[i].lat;
      run_req(vecs[i].a, vecs[i].b, e);
    end

    // start held high with operands churning: one done, then re-acceptance.
    @(negedge clk);
    cur_a = 4'd4;
    cur_b = 4'd6;
    bus.start = 1'b1;
    bus.a = 4'd4;
    bus.b = 4'd6;
    dones = 0;
    done_n = 0;
    for (n = 1; n <= 12; n++) begin
      @(negedge clk);
      bus.a = W'($urandom_range(0, 15));
      bus.b = W'($urandom_range(0, 15));
      if (bus.done === 1'b1) begin
        dones++;
        done_n = n;
        chk("held_gcd", bus.gcd, 2);
        chk("held_lcm", bus.lcm, 12);
        bus.a = 4'd3;
        bus.b = 4'd5;
      end
    end
    chk("held_dones", dones, 1);
    chk("held_latency", done_n, 12);
    @(negedge clk);
    chk("held_idle_gap", bus.busy, 0);
    @(negedge clk);
    cur_a = 4'd3;
    cur_b = 4'd5;
    chk("held_reaccept", bus.busy, 1);
    bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reacc_latency", n, 13);
    chk("reacc_gcd", bus.gcd, 1);
    chk("reacc_lcm", bus.lcm, 15);
    last_g = 4'd1;
    last_l = 8'd15;

    // Reset in the 5th cycle of a=12, b=8 aborts with no done.
    @(negedge clk);
    cur_a = 4'd12;
    cur_b = 4'd8;
    bus.start = 1'b1;
    bus.a = 4'd12;
    bus.b = 4'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    stray = (bus.done === 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_gcd", bus.gcd, 0);
    chk("abort_lcm", bus.lcm, 0);
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) stray = 1;
    end
    chk("abort_no_done", stray, 0);
    rst_n = 1'b1;
    last_g = '0;
    last_l = '0;
    e.g = 4'd4;
    e.l = 8'd24;
    e.lat = 12;
    run_req(4'd12, 4'd8, e);

    // Exhaustive sweep against the reference model.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_req(W'(ia), W'(ib), model(W'(ia), W'(ib)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
